// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter: shares one register-file write port between a pipeline
// writeback source (A) and a buffered multi-cycle mul/div source (B).
// Ports:
//   clk_i, rst_i                     clock, synchronous active-low reset
//   WBRegWrite_i/WBaddr_i/WBdata_i   source A write request
//   MDvalid_i/MDaddr_i/MDdata_i      source B result, accepted when MDready_o
//   MDready_o                        B FIFO has room
//   RegWrite_o/RDaddr_o/RDdata_o     register-file write port
//   stall_o                          freeze pipeline while B is forced through
module regwrite_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        WBRegWrite_i,
    input  logic [4:0]  WBaddr_i,
    input  logic [31:0] WBdata_i,
    input  logic        MDvalid_i,
    input  logic [4:0]  MDaddr_i,
    input  logic [31:0] MDdata_i,
    output logic        MDready_o,
    output logic        RegWrite_o,
    output logic [4:0]  RDaddr_o,
    output logic [31:0] RDdata_o,
    output logic        stall_o
);
    localparam logic A_PRIO = 1'b0;
    localparam logic B_PRIO = 1'b1;

    logic        state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, wr_ptr_q;
    logic [4:0]  addr_q [2];
    logic [31:0] data_q [2];
    logic        a_valid, non_empty, push, pop, grant_a, lose, hit;

    assign a_valid   = WBRegWrite_i & (WBaddr_i != 5'd0);
    assign non_empty = count_q != 2'd0;
    assign MDready_o = rst_i & (count_q != 2'd2);
    // Writes to r0 complete the handshake but are never stored.
    assign push      = MDvalid_i & MDready_o & (MDaddr_i != 5'd0);
    assign grant_a   = rst_i & (state_q == A_PRIO) & a_valid;
    assign pop       = rst_i & non_empty & ((state_q == B_PRIO) | ~a_valid);
    assign stall_o   = rst_i & (state_q == B_PRIO) & a_valid;

    assign RegWrite_o = grant_a | pop;
    assign RDaddr_o   = grant_a ? WBaddr_i : pop ? addr_q[rd_ptr_q] : 5'd0;
    assign RDdata_o   = grant_a ? WBdata_i : pop ? data_q[rd_ptr_q] : 32'd0;

    // The FIFO head lost to A this cycle; reaching the limit forces it next cycle.
    assign lose    = (state_q == A_PRIO) & non_empty & ~pop;
    assign hit     = lose & (cnt_q + 3'd1 == 3'(STARVE_LIMIT));
    assign state_d = hit ? B_PRIO : A_PRIO;
    assign cnt_d   = (lose & ~hit) ? cnt_q + 3'd1 : 3'd0;
    assign count_d = count_q + 2'(push) - 2'(pop);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= A_PRIO;
            cnt_q    <= 3'd0;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_q ^ pop;
            wr_ptr_q <= wr_ptr_q ^ push;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[wr_ptr_q] <= MDaddr_i;
            data_q[wr_ptr_q] <= MDdata_i;
        end
    end
endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb_regwrite_arbiter: randomized and directed bench with a queue-based model.
module tb_regwrite_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_we, md_valid;
    logic [4:0]  wb_addr, md_addr;
    logic [31:0] wb_data, md_data;
    logic        md_ready, reg_write, stall;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    always #5 clk = ~clk;

    regwrite_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .WBRegWrite_i(wb_we), .WBaddr_i(wb_addr), .WBdata_i(wb_data),
        .MDvalid_i(md_valid), .MDaddr_i(md_addr), .MDdata_i(md_data),
        .MDready_o(md_ready), .RegWrite_o(reg_write), .RDaddr_o(rd_addr),
        .RDdata_o(rd_data), .stall_o(stall)
    );

    typedef struct packed {logic [4:0] a; logic [31:0] d;} ent_t;
    ent_t q[$];
    int   checks = 0, errors = 0, losses = 0;
    bit   forced = 0, m_stall = 0, m_acc = 0;
    bit   av, ew, es, er;
    logic [4:0]  ea;
    logic [31:0] ed;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: B results wait in a queue; the head may lose to A LIMIT times in a
    // row, after which it is written next cycle regardless of A.
    always @(negedge clk) begin
        #2;
        av = wb_we && wb_addr != 5'd0;
        {ew, es, er, ea, ed} = '0;
        if (rst_n) begin
            er = q.size() < 2;
            if (forced) begin
                ew = 1; {ea, ed} = q[0]; es = av;
            end else if (av) begin
                ew = 1; ea = wb_addr; ed = wb_data;
            end else if (q.size() > 0) begin
                ew = 1; {ea, ed} = q[0];
            end
        end
        chk("m_regwrite", reg_write, ew);
        chk("m_rdaddr", rd_addr, ea);
        chk("m_rddata", rd_data, ed);
        chk("m_stall", stall, es);
        chk("m_mdready", md_ready, er);
        m_stall = es;
        m_acc = rst_n && md_valid && er;
        if (!rst_n) begin
            q.delete(); losses = 0; forced = 0;
        end else begin
            if (forced) begin
                void'(q.pop_front()); forced = 0; losses = 0;
            end else if (av && q.size() > 0) begin
                losses++;
                if (losses == LIMIT) begin forced = 1; losses = 0; end
            end else begin
                if (q.size() > 0) void'(q.pop_front());
                losses = 0;
            end
            if (m_acc && md_addr != 5'd0) q.push_back({md_addr, md_data});
        end
    end

    // hold=1 obeys the handshakes: A stays put while stalled, B stays put until accepted.
    task automatic cyc(bit r, bit we, logic [4:0] wa, logic [31:0] wd,
                       bit mv, logic [4:0] ma, logic [31:0] md, bit hold = 0);
        @(negedge clk);
        rst_n = r;
        if (!(hold && m_stall)) begin wb_we = we; wb_addr = wa; wb_data = wd; end
        if (!(hold && md_valid && !m_acc)) begin md_valid = mv; md_addr = ma; md_data = md; end
        #1;
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin idle(); n++; end
        chk("drain", 32'(q.size()), 0);
    endtask

    initial begin
        {wb_we, md_valid, wb_addr, md_addr, wb_data, md_data} = '0;
        rst_n = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 3, 32'h33, i == 1, 4, 32'h44);
            chk("rst_regwrite", reg_write, 0);
            chk("rst_mdready", md_ready, 0);
            chk("rst_stall", stall, 0);
        end
        idle();
        chk("rel_regwrite", reg_write, 0);
        chk("rel_stall", stall, 0);
        chk("rel_mdready", md_ready, 1);

        cyc(1, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        chk("a_regwrite", reg_write, 1);
        chk("a_rdaddr", rd_addr, 5);
        chk("a_rddata", rd_data, 32'hDEADBEEF);
        chk("a_stall", stall, 0);

        cyc(1, 0, 0, 0, 1, 9, 32'h12345678);
        chk("b_nobypass", reg_write, 0);
        idle();
        chk("b_regwrite", reg_write, 1);
        chk("b_rdaddr", rd_addr, 9);
        chk("b_rddata", rd_data, 32'h12345678);
        idle();
        chk("b_empty", reg_write, 0);
        cyc(1, 0, 0, 0, 1, 0, 32'hAAAA5555);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("b_r0_dropped", reg_write, 0);
        end

        cyc(1, 1, 1, 32'h100, 1, 3, 32'h300, 1);
        chk("fill_rdy1", md_ready, 1);
        cyc(1, 1, 2, 32'h101, 1, 4, 32'h301, 1);
        chk("fill_rdy2", md_ready, 1);
        cyc(1, 1, 3, 32'h102, 1, 6, 32'h302, 1);
        chk("fill_full", md_ready, 0);
        for (int i = 0; i < 12; i++) cyc(1, 1, 5'(i + 1), 32'(i), 0, 0, 0, 1);
        drain();

        cyc(1, 1, 7, 32'h700, 1, 10, 32'hB0B0);
        chk("st_t0_addr", rd_addr, 7);
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 1, 5'(7 + i), 32'(i), 0, 0, 0);
            chk("st_lose_addr", rd_addr, 7 + i);
            chk("st_lose_stall", stall, 0);
        end
        cyc(1, 1, 20, 32'h2000, 0, 0, 0);
        chk("st_b_regwrite", reg_write, 1);
        chk("st_b_addr", rd_addr, 10);
        chk("st_b_data", rd_data, 32'hB0B0);
        chk("st_b_stall", stall, 1);
        cyc(1, 1, 20, 32'h2000, 0, 0, 0);
        chk("st_a_addr", rd_addr, 20);
        chk("st_a_data", rd_data, 32'h2000);
        chk("st_a_stall", stall, 0);
        idle();

        cyc(1, 1, 1, 1, 1, 11, 32'h11);
        cyc(1, 1, 2, 2, 1, 12, 32'h12);
        cyc(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("rstmid_regwrite", reg_write, 0);
            chk("rstmid_mdready", md_ready, 1);
        end

        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(199) != 0, $urandom_range(99) < 60, 5'($urandom), $urandom,
                $urandom_range(99) < 40, 5'($urandom), $urandom, 1);

        @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, default 4, number of consecutive cycles a pending MD write may lose before it is forced (legal 1..7).
REQ-002 SHALL have port: clk_i  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: WBRegWrite_i  input  1  pipeline writeback request (source A).
REQ-005 SHALL have port: WBaddr_i  input  5  source A destination register.
REQ-006 SHALL have port: WBdata_i  input  32  source A write data.
REQ-007 SHALL have port: MDvalid_i  input  1  multi-cycle mul/div result valid (source B).
REQ-008 SHALL have port: MDaddr_i  input  5  source B destination register.
REQ-009 SHALL have port: MDdata_i  input  32  source B write data.
REQ-010 SHALL have port: MDready_o  output  1  source B may hand over a result this cycle.
REQ-011 SHALL have port: RegWrite_o  output  1  register-file write enable.
REQ-012 SHALL have port: RDaddr_o  output  5  register-file write address.
REQ-013 SHALL have port: RDdata_o  output  32  register-file write data.
REQ-014 SHALL have port: stall_o  output  1  pipeline freeze; source A holds its request stable next cycle.

Function
REQ-015 SHALL share the single register-file write port between A and B, at most one write per cycle; RegWrite_o/RDaddr_o/RDdata_o combinational from current inputs and state.
REQ-016 SHALL buffer source B in a 2-entry FIFO; handshake accept = MDvalid_i & MDready_o; MDready_o = FIFO not full, derived from registered count only.
REQ-017 SHALL discard accepted B results with MDaddr_i = 0 (handshake completes, no push); A requests with WBaddr_i = 0 count as "A invalid".
REQ-018 SHALL not bypass: a B result is written no earlier than the cycle after acceptance.
REQ-019 SHALL implement states A_PRIO and B_PRIO plus 3-bit starve counter cnt.
REQ-020 A_PRIO: A valid -> grant A (RDaddr_o/RDdata_o = WB*); else FIFO non-empty -> grant and pop head; else RegWrite_o = 0; stall_o = 0.
REQ-021 A_PRIO: FIFO non-empty and head not popped -> cnt+1; when cnt+1 = STARVE_LIMIT -> next state B_PRIO, cnt <= 0.
REQ-022 A_PRIO: head popped or FIFO empty -> cnt <= 0.
REQ-023 B_PRIO: grant and pop head unconditionally; stall_o = A valid; next state A_PRIO, cnt <= 0.
REQ-024 SHALL allow push and pop in the same cycle (count unchanged); pop when full frees one slot visible as MDready_o = 1 the next cycle.
REQ-025 SHALL preserve FIFO order for B; no ordering checks between A and B to the same address (upstream hazard unit owns this); a losing head is never dropped.
REQ-026 SHALL drive RDaddr_o = 0, RDdata_o = 0 whenever RegWrite_o = 0.

Reset
REQ-027 SHALL, while rst_i = 0 at a rising edge: empty FIFO, state <= A_PRIO, cnt <= 0.
REQ-028 SHALL force RegWrite_o = 0, stall_o = 0, MDready_o = 0 while rst_i = 0; MDready_o = 1 the first cycle after release.
REQ-029 SHALL discard FIFO contents on reset mid-operation; no write of buffered data after release.

Verification
REQ-030 Reset release, all requests idle -> RegWrite_o = 0, stall_o = 0, MDready_o = 1 on first post-reset cycle.
REQ-031 A only: WBRegWrite_i = 1, WBaddr_i = 5, WBdata_i = 0xDEADBEEF -> same cycle RegWrite_o = 1, RDaddr_o = 5, RDdata_o = 0xDEADBEEF, stall_o = 0.
REQ-032 B only: MDvalid_i pulse addr 9 data 0x12345678 at cycle t -> write addr 9 at cycle t+1, FIFO empty at t+2; MDaddr_i = 0 pulse -> no write ever.
REQ-033 Fill: two B accepts while A busy every cycle -> MDready_o = 0 from third cycle; third MDvalid_i held until ready, not lost.
REQ-034 Starvation, STARVE_LIMIT = 4: A valid every cycle, one B entry -> head loses 4 cycles, 5th cycle B written with stall_o = 1, 6th cycle held A request written, stall_o = 0.
REQ-035 Reset asserted with 2 entries buffered -> after release no B write occurs, MDready_o = 1.
